// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and framing constants for the UART program loader.
package loader_pkg;
    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, WRITE, DONE} state_t;
    localparam logic [7:0] CMD_LOAD_DEFAULT = 8'h4C;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: UART receive handshake, instruction memory write port and loader status.
interface uart_program_loader_if #(parameter int ADDR_W = 10);
    logic enable;
    logic [7:0] r_data;
    logic rx_ready;
    logic rd_uart;
    logic mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic loading;
    logic load_done;
    logic err_count;
    logic err_timeout;
    modport slave (
        input enable, r_data, rx_ready,
        output rd_uart, mem_we, mem_addr, mem_wdata, loading, load_done, err_count, err_timeout
    );
    modport master (
        output enable, r_data, rx_ready,
        input rd_uart, mem_we, mem_addr, mem_wdata, loading, load_done, err_count, err_timeout
    );
endinterface

// File: rtl/loader_timeout.sv
// loader_timeout: inter-byte watchdog; counts cycles since the last consume while a frame is open.
module loader_timeout #(
    parameter int TIMEOUT = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    // cnt holds the number of edges since the last consume, so expiry is flagged one cycle
    // early and the registered error pulse lands exactly TIMEOUT cycles after the consume.
    assign expired = run && cnt == W'(TIMEOUT - 1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt <= '0;
        else if (clear) cnt <= W'(1);
        else if (run && !expired) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_program_loader.sv
// uart_program_loader: parses load frames from the UART and writes packed big-endian words to instruction memory.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter logic [7:0] CMD_LOAD = CMD_LOAD_DEFAULT,
    parameter int TIMEOUT = 50_000_000
) (
    input logic clock,
    input logic reset,
    uart_program_loader_if.slave bus
);
    localparam int BW = $clog2(BYTES_PER_WORD);
    state_t state;
    logic [15:0] n;
    logic [15:0] n_new;
    logic [ADDR_W-1:0] widx;
    logic [BW-1:0] bidx;
    logic [31:0] pack;
    logic blind;
    logic receiving;
    logic expired;
    logic consume;
    logic count_bad;
    logic last_word;
    assign receiving = state == CNT_HI || state == CNT_LO || state == DATA;
    // A consume is never granted in the cycle after one, nor when the watchdog fires.
    assign consume = !reset && bus.rx_ready && !blind && !expired && (receiving || (state == IDLE && bus.enable));
    assign bus.rd_uart = consume;
    assign bus.loading = state != IDLE;
    assign n_new = {n[15:8], bus.r_data};
    assign count_bad = n_new == '0 || 17'(n_new) > (17'd1 << ADDR_W);
    assign last_word = 17'(widx) + 17'd1 == 17'(n);
    loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock(clock),
        .reset(reset),
        .clear(consume),
        .run(receiving),
        .expired(expired)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            n <= '0;
            widx <= '0;
            bidx <= '0;
            pack <= '0;
            blind <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wdata <= '0;
            bus.load_done <= 1'b0;
            bus.err_count <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            blind <= consume;
            bus.mem_we <= 1'b0;
            bus.load_done <= 1'b0;
            bus.err_count <= 1'b0;
            bus.err_timeout <= 1'b0;
            if (receiving && expired) begin
                state <= IDLE;
                bus.err_timeout <= 1'b1;
                bidx <= '0;
                pack <= '0;
            end else begin
                case (state)
                    IDLE: if (consume && bus.r_data == CMD_LOAD) state <= CNT_HI;
                    CNT_HI: if (consume) begin
                        n[15:8] <= bus.r_data;
                        state <= CNT_LO;
                    end
                    CNT_LO: if (consume) begin
                        n[7:0] <= bus.r_data;
                        widx <= '0;
                        bidx <= '0;
                        bus.err_count <= count_bad;
                        state <= count_bad ? IDLE : DATA;
                    end
                    DATA: if (consume) begin
                        pack <= {pack[23:0], bus.r_data};
                        bidx <= bidx + 1'b1;
                        // The word completes on this edge, so the write is registered straight from the incoming byte.
                        if (bidx == BW'(BYTES_PER_WORD - 1)) begin
                            state <= WRITE;
                            bus.mem_we <= 1'b1;
                            bus.mem_addr <= widx;
                            bus.mem_wdata <= {pack[23:0], bus.r_data};
                        end
                    end
                    WRITE: begin
                        state <= last_word ? DONE : DATA;
                        bus.load_done <= last_word;
                        widx <= last_word ? widx : widx + 1'b1;
                        bidx <= '0;
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: randomized frame stimulus checked against a byte-stream frame parser model.
module tb_uart_program_loader;
    localparam int ADDR_W = 10;
    localparam int TIMEOUT = 20;
    typedef logic [7:0] bq_t[$];
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    uart_program_loader_if #(.ADDR_W(ADDR_W)) bus ();
    uart_program_loader #(.ADDR_W(ADDR_W), .CMD_LOAD(8'h4C), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int rd_cnt, done_cnt, ec, et, last_rd_cyc, et_cyc, we_cyc, done_cyc, we_lat;
    logic [ADDR_W+31:0] wq[$];
    logic [ADDR_W+31:0] exp_q[$];
    int exp_done, exp_err;
    logic [ADDR_W+37:0] outs;
    assign outs = {bus.rd_uart, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                   bus.loading, bus.load_done, bus.err_count, bus.err_timeout};
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (bus.rd_uart) begin
            rd_cnt++;
            last_rd_cyc = cyc;
        end
        if (bus.mem_we) begin
            wq.push_back({bus.mem_addr, bus.mem_wdata});
            we_cyc = cyc;
            we_lat = cyc - last_rd_cyc;
        end
        if (bus.load_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.err_count) ec++;
        if (bus.err_timeout) begin
            et++;
            et_cyc = cyc;
        end
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic clear_mon();
        rd_cnt = 0; done_cnt = 0; ec = 0; et = 0;
        last_rd_cyc = 0; et_cyc = 0; we_cyc = 0; done_cyc = 0; we_lat = 0;
        wq.delete();
    endtask
    // Frame parser working on whole bytes: junk outside frames is dropped, each good frame yields N words.
    task automatic model(input bq_t s);
        int i;
        int cnt;
        exp_q.delete();
        exp_done = 0;
        exp_err = 0;
        i = 0;
        while (i < s.size()) begin
            if (s[i] != 8'h4C) begin
                i++;
            end else begin
                cnt = int'({s[i+1], s[i+2]});
                i += 3;
                if (cnt == 0 || cnt > (1 << ADDR_W)) begin
                    exp_err++;
                end else begin
                    for (int k = 0; k < cnt; k++) begin
                        exp_q.push_back({ADDR_W'(k), s[i], s[i+1], s[i+2], s[i+3]});
                        i += 4;
                    end
                    exp_done++;
                end
            end
        end
    endtask
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic got;
        got = 1'b0;
        repeat (gap) begin @(posedge clock); #1; end
        bus.r_data = b;
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            got = bus.rd_uart;
        end
        check("rd_uart_wait", 64'(got), 64'd1);
        // Hold the byte through the blind cycle, as a UART with a lagging status flag would.
        repeat (2) begin @(posedge clock); #1; end
        bus.rx_ready = 1'b0;
    endtask
    task automatic make_frame(inout bq_t s, input int cnt, input int junk);
        logic [7:0] j;
        for (int i = 0; i < junk; i++) begin
            j = 8'($urandom);
            s.push_back(j == 8'h4C ? 8'h4D : j);
        end
        s.push_back(8'h4C);
        s.push_back(8'(cnt >> 8));
        s.push_back(8'(cnt));
        for (int i = 0; i < 4 * cnt && cnt <= (1 << ADDR_W); i++) s.push_back(8'($urandom));
    endtask
    task automatic run_stream(input bq_t s, input int maxgap);
        model(s);
        clear_mon();
        foreach (s[i]) send_byte(s[i], int'($urandom_range(maxgap, 0)));
        repeat (8) begin @(posedge clock); #1; end
        check("rd_count", 64'(rd_cnt), 64'(s.size()));
        check("write_count", 64'(wq.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) if (i < wq.size()) check("write", 64'(wq[i]), 64'(exp_q[i]));
        check("load_done", 64'(done_cnt), 64'(exp_done));
        check("err_count", 64'(ec), 64'(exp_err));
        check("err_timeout", 64'(et), 64'd0);
        check("loading_idle", 64'(bus.loading), 64'd0);
        if (exp_done > 0) begin
            check("done_latency", 64'(done_cyc - we_cyc), 64'd1);
            check("we_latency", 64'(we_lat), 64'd1);
        end
    endtask
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        bq_t s;
        bus.enable = 1'b1;
        bus.rx_ready = 1'b1;
        bus.r_data = 8'h4C;
        repeat (3) begin @(posedge clock); #1; end
        check("reset_outputs", 64'(outs), 64'd0);
        reset = 1'b0;
        bus.rx_ready = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        check("post_reset_loading", 64'(bus.loading), 64'd0);
        s = '{8'h4C, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        run_stream(s, 2);
        check("word0", 64'(wq[0]), 64'({10'd0, 32'hDEADBEEF}));
        check("word1", 64'(wq[1]), 64'({10'd1, 32'h01020304}));
        s = '{8'h4C, 8'h00, 8'h00};
        run_stream(s, 1);
        s = '{8'h4C, 8'h04, 8'h01};
        run_stream(s, 1);
        s = '{8'h55, 8'h4C, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        run_stream(s, 3);
        check("junk_word", 64'(wq[0]), 64'({10'd0, 32'h11223344}));
        s.delete();
        make_frame(s, 1 << ADDR_W, 0);
        run_stream(s, 1);
        for (int r = 0; r < 8; r++) begin
            s.delete();
            make_frame(s, r == 3 ? 0 : int'($urandom_range(6, 1)), int'($urandom_range(2, 0)));
            if (r == 5) make_frame(s, int'($urandom_range(3, 1)), 1);
            run_stream(s, 4);
        end
        clear_mon();
        bus.enable = 1'b0;
        bus.r_data = 8'h4C;
        bus.rx_ready = 1'b1;
        repeat (10) begin @(posedge clock); #1; end
        check("disabled_rd", 64'(rd_cnt), 64'd0);
        check("disabled_loading", 64'(bus.loading), 64'd0);
        bus.enable = 1'b1;
        send_byte(8'h4C, 0);
        check("stall_single_rd", 64'(rd_cnt), 64'd1);
        check("loading_rise", 64'(bus.loading), 64'd1);
        bus.enable = 1'b0;
        s = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        foreach (s[i]) send_byte(s[i], 1);
        repeat (4) begin @(posedge clock); #1; end
        check("enable_drop_rd", 64'(rd_cnt), 64'd7);
        check("enable_drop_writes", 64'(wq.size()), 64'd1);
        check("enable_drop_word", 64'(wq[0]), 64'({10'd0, 32'hCAFEF00D}));
        bus.enable = 1'b1;
        clear_mon();
        s = '{8'h4C, 8'h00, 8'h01, 8'hAA, 8'hBB};
        foreach (s[i]) send_byte(s[i], 0);
        repeat (30) begin @(posedge clock); #1; end
        check("timeout_pulses", 64'(et), 64'd1);
        check("timeout_delay", 64'(et_cyc - last_rd_cyc), 64'(TIMEOUT));
        check("timeout_writes", 64'(wq.size()), 64'd0);
        check("timeout_loading", 64'(bus.loading), 64'd0);
        clear_mon();
        s = '{8'h4C, 8'h00, 8'h01, 8'hAA};
        foreach (s[i]) send_byte(s[i], 1);
        @(posedge clock);
        #2;
        bus.r_data = 8'hBB;
        bus.rx_ready = 1'b1;
        reset = 1'b1;
        #1;
        check("reset_async", 64'(outs), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus.rx_ready = 1'b0;
        check("reset_no_write", 64'(wq.size()), 64'd0);
        s.delete();
        make_frame(s, 2, 0);
        run_stream(s, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
